// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt-control core.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } pic_state_e;

    localparam logic [2:0] OCW2_NSEOI   = 3'b001;
    localparam logic [2:0] OCW2_SEOI    = 3'b011;
    localparam logic [2:0] SPURIOUS_IDX = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/pic_control_logic_if.sv
// Write-strobe, request, acknowledge and register-readback bundle between
// the read/write logic (master) and the interrupt-control core (slave).
interface pic_control_logic_if;

    logic [7:0] wr_data;
    logic [3:0] icw_stb;
    logic [2:0] ocw_stb;
    logic [7:0] ir;
    logic       inta_n;
    logic       int_out;
    logic [7:0] vec_data;
    logic       vec_oe;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;

    modport master (
        output wr_data, icw_stb, ocw_stb, ir, inta_n,
        input  int_out, vec_data, vec_oe, irr, isr, imr
    );

    modport slave (
        input  wr_data, icw_stb, ocw_stb, ir, inta_n,
        output int_out, vec_data, vec_oe, irr, isr, imr
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// Fixed-priority resolver: reports whether any bit is set and the index of
// the lowest set bit (bit 0 is the highest priority).
module pic_priority_resolver (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    // Lowest-index-wins encoder
    always_comb begin
        valid_o = |req_i;
        casez (req_i)
            8'b???????1: idx_o = 3'd0;
            8'b??????10: idx_o = 3'd1;
            8'b?????100: idx_o = 3'd2;
            8'b????1000: idx_o = 3'd3;
            8'b???10000: idx_o = 3'd4;
            8'b??100000: idx_o = 3'd5;
            8'b?1000000: idx_o = 3'd6;
            8'b10000000: idx_o = 3'd7;
            default:     idx_o = 3'd0;
        endcase
    end

endmodule

// File: rtl/pic_control_logic.sv
// 8259A-style interrupt-control core: IRR/IMR/ISR, fixed priority, INT
// generation and the two-pulse INTA sequence that places the vector.
module pic_control_logic
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pic_control_logic_if.slave bus
);

    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic       int_out_q, int_out_d;
    logic [7:0] ir_prev_q;
    logic       inta_prev_q;
    logic [4:0] vec_base_q;
    logic       ltim_q;
    logic       aeoi_q;

    pic_state_e state_q;
    logic [2:0] idx_q;
    logic       spur_q;
    logic [7:0] vec_data_q;
    logic       vec_oe_q;

    logic       icw1_s, icw2_s, icw4_s, ocw1_s, ocw2_s;
    logic       fall_s, take_s, release_s;
    logic [7:0] pend_s;
    logic       pend_valid_s, isr_valid_s;
    logic [2:0] pend_idx_s, isr_idx_s;
    logic [7:0] ack_bit_s, eoi_clr_s, aeoi_clr_s;
    logic       unused_s;

    assign icw1_s = bus.icw_stb[0];
    assign icw2_s = bus.icw_stb[1];
    assign icw4_s = bus.icw_stb[3];
    assign ocw1_s = bus.ocw_stb[0];
    assign ocw2_s = bus.ocw_stb[1];
    // ICW3 (single PIC) and OCW3 have no effect on this block.
    assign unused_s = bus.icw_stb[2] ^ bus.ocw_stb[2];

    // An ICW1 in the same cycle discards any inta_n edge.
    assign fall_s    = inta_prev_q & ~bus.inta_n & ~icw1_s;
    assign take_s    = (state_q == ST_IDLE) && fall_s;
    assign release_s = (state_q == ST_ACK2) && bus.inta_n && !icw1_s;

    assign pend_s = irr_q & ~imr_q;

    pic_priority_resolver u_pend_res (
        .req_i   (pend_s),
        .valid_o (pend_valid_s),
        .idx_o   (pend_idx_s)
    );

    pic_priority_resolver u_isr_res (
        .req_i   (isr_q),
        .valid_o (isr_valid_s),
        .idx_o   (isr_idx_s)
    );

    // Bits to set/clear in ISR this cycle from acknowledge, EOI and AEOI
    always_comb begin
        if (take_s && pend_valid_s) begin
            ack_bit_s = onehot8(pend_idx_s);
        end else begin
            ack_bit_s = 8'h00;
        end
        if (ocw2_s) begin
            case (bus.wr_data[7:5])
                OCW2_NSEOI: eoi_clr_s = isr_valid_s ? onehot8(isr_idx_s) : 8'h00;
                OCW2_SEOI:  eoi_clr_s = onehot8(bus.wr_data[2:0]);
                default:    eoi_clr_s = 8'h00;
            endcase
        end else begin
            eoi_clr_s = 8'h00;
        end
        if (release_s && aeoi_q && !spur_q) begin
            aeoi_clr_s = onehot8(idx_q);
        end else begin
            aeoi_clr_s = 8'h00;
        end
    end

    // Next-state for the request/service/mask registers and INT
    always_comb begin
        if (icw1_s) begin
            irr_d     = 8'h00;
            isr_d     = 8'h00;
            imr_d     = 8'h00;
            int_out_d = 1'b0;
        end else begin
            if (ltim_q) begin
                irr_d = bus.ir;
            end else begin
                irr_d = (irr_q & ~ack_bit_s) | (bus.ir & ~ir_prev_q);
            end
            // Set is applied after the clears so it wins on the same bit.
            isr_d = (isr_q & ~eoi_clr_s & ~aeoi_clr_s) | ack_bit_s;
            if (ocw1_s) begin
                imr_d = bus.wr_data;
            end else begin
                imr_d = imr_q;
            end
            if (take_s) begin
                int_out_d = 1'b0;
            end else begin
                int_out_d = pend_valid_s && (!isr_valid_s || (pend_idx_s < isr_idx_s));
            end
        end
    end

    // Register file, edge history and init-word configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            imr_q       <= 8'hFF;
            int_out_q   <= 1'b0;
            ir_prev_q   <= 8'h00;
            inta_prev_q <= 1'b1;
            vec_base_q  <= 5'd0;
            ltim_q      <= 1'b0;
            aeoi_q      <= 1'b0;
        end else begin
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            int_out_q   <= int_out_d;
            ir_prev_q   <= icw1_s ? 8'h00 : bus.ir;
            inta_prev_q <= bus.inta_n;
            if (icw1_s) begin
                ltim_q <= bus.wr_data[3];
                aeoi_q <= 1'b0;
            end else if (icw4_s) begin
                aeoi_q <= bus.wr_data[1];
            end else if (icw2_s) begin
                vec_base_q <= bus.wr_data[7:3];
            end else begin
                ltim_q <= ltim_q;
            end
        end
    end

    // INTA sequencer with registered vector outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            spur_q     <= 1'b0;
            vec_data_q <= 8'h00;
            vec_oe_q   <= 1'b0;
        end else if (icw1_s) begin
            state_q  <= ST_IDLE;
            vec_oe_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        idx_q   <= pend_valid_s ? pend_idx_s : SPURIOUS_IDX;
                        spur_q  <= !pend_valid_s;
                        state_q <= ST_ACK1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACK1: begin
                    if (fall_s) begin
                        vec_data_q <= {vec_base_q, idx_q};
                        vec_oe_q   <= 1'b1;
                        state_q    <= ST_ACK2;
                    end else begin
                        state_q <= ST_ACK1;
                    end
                end
                ST_ACK2: begin
                    if (bus.inta_n) begin
                        vec_oe_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_ACK2;
                    end
                end
                default: begin
                    vec_oe_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.irr      = irr_q;
    assign bus.isr      = isr_q;
    assign bus.imr      = imr_q;
    assign bus.int_out  = int_out_q;
    assign bus.vec_data = vec_data_q;
    assign bus.vec_oe   = vec_oe_q;

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed test-plan steps followed by random traffic, all checked against a
// behavioural PIC model kept in the bench.
module tb_pic_control_logic;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nfail;

    pic_control_logic_if bus_if ();

    pic_control_logic dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] m_irr, m_isr, m_imr, m_vec, m_irprev;
    logic [4:0] m_base;
    logic       m_ltim, m_aeoi, m_int, m_oe, m_intaprev, m_spur;
    int         m_phase, m_idx;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_vec = 8'h00;
        m_base = 5'd0; m_ltim = 1'b0; m_aeoi = 1'b0; m_int = 1'b0; m_oe = 1'b0;
        m_phase = 0; m_idx = 0; m_spur = 1'b0; m_irprev = 8'h00; m_intaprev = 1'b1;
    endtask

    task automatic model_step();
        logic [7:0] d, pend, nirr, nisr;
        int p, ip, ack, aclr, eoi;
        bit fall, nint;
        d = bus_if.wr_data;
        if (bus_if.icw_stb[0]) begin
            m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_ltim = d[3]; m_aeoi = 1'b0;
            m_int = 1'b0; m_oe = 1'b0; m_phase = 0; m_irprev = 8'h00;
            m_intaprev = bus_if.inta_n;
        end else begin
            pend = m_irr & ~m_imr;
            p    = lowest(pend);
            ip   = lowest(m_isr);
            fall = m_intaprev && !bus_if.inta_n;
            nint = (p >= 0) && (ip < 0 || p < ip);
            ack = -1; aclr = -1; eoi = -1;
            if (bus_if.ocw_stb[1]) begin
                if (d[7:5] == 3'b001) eoi = ip;
                else if (d[7:5] == 3'b011) eoi = int'(d[2:0]);
            end
            if (m_phase == 0) begin
                if (fall) begin
                    m_phase = 1; nint = 1'b0;
                    if (p >= 0) begin ack = p; m_idx = p; m_spur = 1'b0; end
                    else begin m_idx = 7; m_spur = 1'b1; end
                end
            end else if (m_phase == 1) begin
                if (fall) begin
                    m_phase = 2; m_oe = 1'b1; m_vec = {m_base, 3'(m_idx)};
                end
            end else begin
                if (bus_if.inta_n) begin
                    m_phase = 0; m_oe = 1'b0;
                    if (m_aeoi && !m_spur) aclr = m_idx;
                end
            end
            nisr = m_isr;
            if (eoi >= 0)  nisr[eoi]  = 1'b0;
            if (aclr >= 0) nisr[aclr] = 1'b0;
            if (ack >= 0)  nisr[ack]  = 1'b1;
            if (m_ltim) nirr = bus_if.ir;
            else begin
                nirr = m_irr;
                if (ack >= 0) nirr[ack] = 1'b0;
                nirr = nirr | (bus_if.ir & ~m_irprev);
            end
            if (bus_if.icw_stb[1]) m_base = d[7:3];
            if (bus_if.icw_stb[3]) m_aeoi = d[1];
            if (bus_if.ocw_stb[0]) m_imr = d;
            m_irr = nirr; m_isr = nisr; m_int = nint;
            m_irprev = bus_if.ir; m_intaprev = bus_if.inta_n;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":irr"},  bus_if.irr,              m_irr);
        chk({where, ":isr"},  bus_if.isr,              m_isr);
        chk({where, ":imr"},  bus_if.imr,              m_imr);
        chk({where, ":int"},  {7'd0, bus_if.int_out},  {7'd0, m_int});
        chk({where, ":oe"},   {7'd0, bus_if.vec_oe},   {7'd0, m_oe});
        chk({where, ":vec"},  bus_if.vec_data,         m_vec);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all("cyc");
        bus_if.icw_stb = 4'd0;
        bus_if.ocw_stb = 3'd0;
    endtask

    task automatic icw(input int n, input logic [7:0] d);
        bus_if.icw_stb = 4'(1 << n);
        bus_if.wr_data = d;
        cyc();
    endtask

    task automatic ocw(input int n, input logic [7:0] d);
        bus_if.ocw_stb = 3'(1 << n);
        bus_if.wr_data = d;
        cyc();
    endtask

    task automatic pulse_ir(input logic [7:0] v);
        bus_if.ir = v; cyc();
        bus_if.ir = 8'h00; cyc();
    endtask

    task automatic ack_seq(output logic [7:0] isr_p1, output logic oe_p1,
                           output logic oe_p2, output logic [7:0] vec_p2, output logic oe_end);
        bus_if.inta_n = 1'b0; cyc(); isr_p1 = bus_if.isr; oe_p1 = bus_if.vec_oe;
        bus_if.inta_n = 1'b1; cyc();
        bus_if.inta_n = 1'b0; cyc(); oe_p2 = bus_if.vec_oe; vec_p2 = bus_if.vec_data;
        bus_if.inta_n = 1'b1; cyc(); oe_end = bus_if.vec_oe;
    endtask

    initial begin
        logic [7:0] isr1, vec2, r;
        logic       oe1, oe2, oe3;
        int         sel;
        nvec = 0; nfail = 0;
        bus_if.wr_data = 8'h00; bus_if.icw_stb = 4'd0; bus_if.ocw_stb = 3'd0;
        bus_if.ir = 8'h00; bus_if.inta_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst:imr", bus_if.imr, 8'hFF);
        chk("rst:int", {7'd0, bus_if.int_out}, 8'h00);
        check_all("rst");
        rst_n = 1'b1;

        // Edge mode basic acknowledge of IR3
        icw(0, 8'h13); icw(1, 8'h40); icw(3, 8'h01); ocw(0, 8'h00);
        bus_if.ir = 8'h08; cyc();
        chk("t1:irr", bus_if.irr, 8'h08);
        bus_if.ir = 8'h00; cyc();
        chk("t1:int", {7'd0, bus_if.int_out}, 8'h01);
        ack_seq(isr1, oe1, oe2, vec2, oe3);
        chk("t1:isr", isr1, 8'h08);
        chk("t1:oe1", {7'd0, oe1}, 8'h00);
        chk("t1:oe2", {7'd0, oe2}, 8'h01);
        chk("t1:vec", vec2, 8'h43);
        chk("t1:oe3", {7'd0, oe3}, 8'h00);
        chk("t1:irr0", bus_if.irr, 8'h00);
        ocw(1, 8'h63);

        // Two simultaneous requests, then non-specific EOI
        pulse_ir(8'h24);
        ack_seq(isr1, oe1, oe2, vec2, oe3);
        chk("t2:isr", isr1, 8'h04);
        chk("t2:vec", vec2, 8'h42);
        ocw(1, 8'h20);
        chk("t2:isr0", bus_if.isr, 8'h00);
        cyc();
        chk("t2:int5", {7'd0, bus_if.int_out}, 8'h01);
        ack_seq(isr1, oe1, oe2, vec2, oe3);
        chk("t2:vec5", vec2, 8'h45);
        ocw(1, 8'h65);

        // Masking
        ocw(0, 8'h08);
        pulse_ir(8'h08);
        chk("t3:irr", bus_if.irr, 8'h08);
        chk("t3:int0", {7'd0, bus_if.int_out}, 8'h00);
        ocw(0, 8'h00); cyc();
        chk("t3:int1", {7'd0, bus_if.int_out}, 8'h01);
        ack_seq(isr1, oe1, oe2, vec2, oe3);
        ocw(1, 8'h63);

        // Automatic EOI
        icw(0, 8'h13); icw(1, 8'h40); icw(3, 8'h03); ocw(0, 8'h00);
        pulse_ir(8'h40);
        ack_seq(isr1, oe1, oe2, vec2, oe3);
        chk("t4:isr1", isr1, 8'h40);
        chk("t4:vec", vec2, 8'h46);
        chk("t4:isr0", bus_if.isr, 8'h00);

        // Level mode spurious acknowledge
        icw(0, 8'h1B); icw(1, 8'h40); icw(3, 8'h01); ocw(0, 8'h00);
        bus_if.ir = 8'h10; cyc(); cyc();
        chk("t5:irr", bus_if.irr, 8'h10);
        bus_if.ir = 8'h00; cyc(); cyc();
        ack_seq(isr1, oe1, oe2, vec2, oe3);
        chk("t5:isr", isr1, 8'h00);
        chk("t5:vec", vec2, 8'h47);

        // ICW1 between the two INTA pulses aborts the cycle
        icw(0, 8'h13); icw(1, 8'h40); icw(3, 8'h01); ocw(0, 8'h00);
        pulse_ir(8'h02);
        bus_if.inta_n = 1'b0; cyc();
        chk("t6:isr1", bus_if.isr, 8'h02);
        bus_if.inta_n = 1'b1; icw(0, 8'h13);
        bus_if.inta_n = 1'b0; cyc();
        chk("t6:oe", {7'd0, bus_if.vec_oe}, 8'h00);
        chk("t6:isr", bus_if.isr, 8'h00);
        chk("t6:imr", bus_if.imr, 8'h00);
        bus_if.inta_n = 1'b1; cyc();
        icw(1, 8'hA8);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            r = 8'($urandom & $urandom & $urandom);
            bus_if.ir = bus_if.ir ^ r;
            if ($urandom_range(0, 3) == 0) bus_if.inta_n = ~bus_if.inta_n;
            bus_if.wr_data = 8'($urandom);
            sel = $urandom_range(0, 99);
            if (sel < 3)       bus_if.icw_stb = 4'b0001;
            else if (sel < 7)  bus_if.icw_stb = 4'b0010;
            else if (sel < 10) bus_if.icw_stb = 4'b1000;
            else if (sel < 12) bus_if.icw_stb = 4'b0100;
            else if (sel < 18) begin
                bus_if.wr_data = 8'($urandom & $urandom);
                bus_if.ocw_stb = 3'b001;
            end else if (sel < 30) begin
                r = 8'($urandom);
                if (r[7]) bus_if.wr_data[7:5] = 3'b001;
                else if (r[6]) bus_if.wr_data[7:5] = 3'b011;
                bus_if.ocw_stb = 3'b010;
            end else if (sel < 33) bus_if.ocw_stb = 3'b100;
            cyc();
        end

        // Asynchronous reset in mid-cycle
        bus_if.ir = 8'h00; bus_if.inta_n = 1'b1;
        @(posedge clk); model_step();
        #3; rst_n = 1'b0;
        #1; model_reset();
        chk("arst:imr", bus_if.imr, 8'hFF);
        check_all("arst");
        #2; rst_n = 1'b1;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Clocked interrupt-control core of the 8259A PIC, directly downstream of the read/write logic. It consumes the ICW/OCW write strobes and the written data byte, and holds the IRR, IMR and ISR registers. It also resolves fixed priority, drives INT, and sequences the two-pulse 8086-mode INTA cycle, placing the vector on the bus during the second pulse. IRR, ISR and IMR are exported back to the read path.

## Interface
- No parameters. Single PIC only: ICW3 is accepted and ignored; no cascade.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_data  in  8  data byte of the current write, valid with any strobe
- icw_stb  in  4  one-cycle pulses; bit0=ICW1 … bit3=ICW4; at most one of icw_stb/ocw_stb set per cycle
- ocw_stb  in  3  one-cycle pulses; bit0=OCW1, bit1=OCW2, bit2=OCW3
- ir  in  8  interrupt request lines, already synchronous to clk
- inta_n  in  1  interrupt acknowledge, active low, synchronous to clk
- int_out  out  1  interrupt request to CPU
- vec_data  out  8  vector byte
- vec_oe  out  1  vector drive enable
- irr  out  8  interrupt request register
- isr  out  8  in-service register
- imr  out  8  interrupt mask register

## Operation
- Reset values:
  - irr, isr, vec_data, vec_base, ltim and aeoi are all 0.
  - imr is 0xFF.
  - int_out and vec_oe are 0.
  - FSM is IDLE.
- ICW1:
  - Clears isr and imr to 0x00 and irr to 0.
  - ltim = wr_data[3].
  - aeoi = 0.
  - Clears the ir edge history and forces the FSM to IDLE with vec_oe=0, aborting any INTA cycle.
- ICW2: vec_base = wr_data[7:3].
- ICW4: aeoi = wr_data[1].
- OCW1: imr = wr_data.
- OCW2, command = wr_data[7:5]:
  - 001 (non-specific EOI): clear the highest-priority set isr bit.
  - 011 (specific EOI): clear isr[wr_data[2:0]].
  - All other codes are ignored; rotation is not supported.
- OCW3: no effect here.
- IRR, edge mode (ltim=0): irr[i] is set on a 0→1 of ir[i] (previous-cycle register). It clears when bit i is acknowledged.
- IRR, level mode (ltim=1): irr[i] follows ir[i] each cycle.
- Simultaneous set and acknowledge-clear of the same irr bit: set wins.
- Priority is fixed, IR0 highest.
  - pend = irr & ~imr; p = lowest index set in pend.
  - int_out is asserted when pend≠0 and p is higher priority than every set isr bit (or isr = 0).
- INTA FSM states: IDLE, ACK1, ACK2.
  - Falling edge = inta_n sampled 1 last cycle and 0 this cycle.
  - IDLE → ACK1 on a falling edge.
    - If pend≠0: latch p, set isr[p], clear irr[p].
    - Else (spurious): latch 7, leave isr unchanged.
    - int_out drops.
  - ACK1 → ACK2 on the next falling edge. vec_data = {vec_base, latched index}, vec_oe=1.
  - ACK2 → IDLE when inta_n returns to 1. vec_oe=0.
    - If aeoi and not spurious, clear isr[latched index] in the same cycle.
- Simultaneous EOI and ISR set:
  - Different bits: both apply.
  - Same bit: set wins.

## Timing
- irr updates 1 cycle after the ir edge or level change.
- int_out is registered and reflects irr/imr/isr one cycle after they change.
- isr/irr update and int_out deassertion occur on the clock edge that samples the first inta_n falling edge.
- vec_oe and vec_data are registered.
  - Valid from the clock edge sampling the second falling edge.
  - Held until the edge sampling inta_n high.
- OCW/ICW strobes take effect on the clock edge at which they are high; register outputs show the new value the following cycle.
- ICW1 in the same cycle as an inta_n edge: ICW1 wins and the edge is discarded.
- rst_n low mid-cycle immediately forces all reset values.

## Structure
- Shared package pic_pkg holds:
  - the FSM state enum (IDLE/ACK1/ACK2)
  - OCW2 command constants (NSEOI=3'b001, SEOI=3'b011)
  - SPURIOUS_IDX=3'd7
- Sub-module pic_priority_resolver: combinational; inputs an 8-bit vector; outputs valid plus the 3-bit index of the lowest set bit. It is instantiated twice: for pend and for isr.

## Test plan
- ICW1=0x13, ICW2=0x40, ICW4=0x01, OCW1=0x00; pulse ir[3] → irr=0x08, int_out=1; two INTA pulses → isr=0x08, irr=0, vec_data=0x43 with vec_oe=1 during the second pulse only.
- Raise ir[5] and ir[2] together → after ack isr=0x04, vector 0x42; then OCW2=0x20 (NSEOI) → isr=0x00 and int_out reasserts for IR5.
- OCW1=0x08, raise ir[3] → irr=0x08, int_out=0; OCW1=0x00 → int_out=1 next cycle.
- Re-init with ICW4=0x03 (AEOI): ack ir[6] → vector 0x46, isr=0x00 after the second inta_n rises.
- Raise ir[4], drop it before INTA (level mode, ICW1=0x1B) → first pulse spurious; vector 0x47; isr stays 0x00.
- ICW1 write between the two INTA pulses → FSM IDLE, vec_oe stays 0 on the second pulse, isr=0x00, imr=0x00.
